// File: rtl/alu_mc_pkg.sv
// Shared opcode values, FSM state encoding and helpers for the multi-cycle ALU.
package alu_mc_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL1 = 4'd4;
  localparam logic [3:0] OP_SHR1 = 4'd5;
  localparam logic [3:0] OP_ROL1 = 4'd6;
  localparam logic [3:0] OP_ROR1 = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_multi(input logic [3:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIV);
  endfunction
endpackage

// File: rtl/alu_mc_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one hi:lo register pair.
module alu_iter_muldiv #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,       // 0 = MUL, 1 = DIV
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  hi_nonzero,
  output logic                  div0
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [W-1:0]  hi, lo, bv, hi_n, lo_n;
  logic [CW-1:0] cnt;
  logic          mode_r, div0_r;
  logic [W:0]    sum, rs, diff;

  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, bv} : '0);
    rs   = {hi, lo[W-1]};
    diff = rs - {1'b0, bv};
    if (!mode_r) begin
      {hi_n, lo_n} = {sum, lo[W-1:1]};
    end else if (!div0_r) begin
      // Remainder < divisor, so a non-negative difference always fits in W bits.
      if (!diff[W]) begin
        hi_n = diff[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = rs[W-1:0];
        lo_n = {lo[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      bv     <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
      div0_r <= 1'b0;
    end else if (start) begin
      hi     <= '0;
      lo     <= a;
      bv     <= b;
      mode_r <= mode;
      div0_r <= (b == '0);
      cnt    <= CW'(DATA_WIDTH);
    end else if (cnt != '0) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
    end
  end

  // Results are taken from the final step's next-state so the caller sees them on that edge.
  assign done       = (cnt == CW'(1));
  assign result     = (mode_r && div0_r) ? '1 : lo_n;
  assign hi_nonzero = !mode_r && (hi_n != '0);
  assign div0       = mode_r && div0_r;
endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle ops register in one cycle, MUL/DIV iterate.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [SEL_WIDTH-1:0]  Sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] Out,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  Negative,
  output logic                  Overflow,
  output logic                  DivByZero,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int W   = DATA_WIDTH;
  localparam int MSB = DATA_WIDTH - 1;

  state_t       state;
  logic         accept, md_done, md_hi_nz, md_div0;
  logic [W-1:0] md_res, sc_out;
  logic         sc_c, sc_v;
  logic [W:0]   add_w, sub_w;

  assign in_ready  = !reset && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);

  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (Sel)
      OP_ADD: begin
        sc_out = add_w[W-1:0];
        sc_c   = add_w[W];
        sc_v   = (A[MSB] == B[MSB]) && (add_w[MSB] != A[MSB]);
      end
      OP_SUB: begin
        sc_out = sub_w[W-1:0];
        sc_c   = sub_w[W];  // borrow: set iff A < B
        sc_v   = (A[MSB] != B[MSB]) && (sub_w[MSB] != A[MSB]);
      end
      OP_SHL1: begin sc_out = {A[W-2:0], 1'b0};   sc_c = A[MSB]; end
      OP_SHR1: begin sc_out = {1'b0, A[W-1:1]};   sc_c = A[0];   end
      OP_ROL1: begin sc_out = {A[W-2:0], A[MSB]}; sc_c = A[MSB]; end
      OP_ROR1: begin sc_out = {A[0], A[W-1:1]};   sc_c = A[0];   end
      OP_AND:  sc_out = A & B;
      OP_OR:   sc_out = A | B;
      OP_XOR:  sc_out = A ^ B;
      OP_NOR:  sc_out = ~(A | B);
      OP_NAND: sc_out = ~(A & B);
      OP_XNOR: sc_out = ~(A ^ B);
      OP_GT:   sc_out = {{(W-1){1'b0}}, (A > B)};
      OP_EQ:   sc_out = {{(W-1){1'b0}}, (A == B)};
      default: ;
    endcase
  end

  alu_iter_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .start      (accept && is_multi(Sel)),
    .mode       (Sel == OP_DIV),
    .a          (A),
    .b          (B),
    .done       (md_done),
    .result     (md_res),
    .hi_nonzero (md_hi_nz),
    .div0       (md_div0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      Out       <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        S_BUSY: begin
          if (md_done) begin
            state     <= S_DONE;
            Out       <= md_res;
            CarryOut  <= md_hi_nz;
            Zero      <= (md_res == '0);
            Negative  <= md_res[MSB];
            Overflow  <= 1'b0;
            DivByZero <= md_div0;
          end
        end
        default: begin
          if (accept) begin
            if (is_multi(Sel)) begin
              state <= S_BUSY;
            end else begin
              state     <= S_DONE;
              Out       <= sc_out;
              CarryOut  <= sc_c;
              Zero      <= (sc_out == '0);
              Negative  <= sc_out[MSB];
              Overflow  <= sc_v;
              DivByZero <= 1'b0;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
